// File: rtl/memory_port_arbiter_pkg.sv
// Shared encodings for the unified memory port arbiter: FSM states, requester IDs
// and the mapping from a granted requester to its wait state.
package memory_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE       = 2'd0,
        ARB_FETCH_WAIT = 2'd1,
        ARB_LOAD_WAIT  = 2'd2,
        ARB_STORE_WAIT = 2'd3
    } memArbState_;

    typedef enum logic [1:0] {
        REQ_FETCH = 2'd0,
        REQ_LOAD  = 2'd1,
        REQ_STORE = 2'd2
    } memRequester_;

    function automatic memArbState_ wait_state_for(input memRequester_ req);
        memArbState_ st;
        case (req)
            REQ_FETCH: st = ARB_FETCH_WAIT;
            REQ_LOAD:  st = ARB_LOAD_WAIT;
            REQ_STORE: st = ARB_STORE_WAIT;
            default:   st = ARB_IDLE;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/memory_port_arbiter.sv
// Shares one memory port between instruction fetch and the Memory stage, one transaction
// at a time. Optional wait-state timeout abort is enabled by defining MEM_ARB_TIMEOUT_EN.
module memory_port_arbiter
    import memory_port_arbiter_pkg::*;
#(
    parameter int FETCH_STARVE_LIMIT = 4
`ifdef MEM_ARB_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 256
`endif
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fetchRequest,
    input  logic [31:0] fetchAddress,
    input  logic        fetchFlush,
    output logic [31:0] fetchData,
    output logic        fetchValid,
    input  logic        loadRequest,
    input  logic        storeValid,
    input  logic [31:0] addressRegister,
    input  logic [31:0] storeData,
    input  logic [3:0]  storeByteEnable,
    output logic [31:0] loadData,
    output logic        loadDataValid,
    output logic        storeComplete,
    output logic        memRequest,
    output logic        memWrite,
    output logic [31:0] memAddress,
    output logic [31:0] memWriteData,
    output logic [3:0]  memByteEnable,
    input  logic [31:0] memReadData,
    input  logic        memResponseValid,
    output logic        busError
);

    localparam int STARVE_W = $clog2(FETCH_STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(FETCH_STARVE_LIMIT);
    localparam logic [STARVE_W-1:0] STARVE_ONE = STARVE_W'(1);

    memArbState_         state_r;
    memArbState_         state_s;
    logic [STARVE_W-1:0] starve_r;
    logic                drain_r;
    logic                mem_req_r;
    logic                mem_write_r;
    logic [31:0]         mem_addr_r;
    logic [31:0]         mem_wdata_r;
    logic [3:0]          mem_be_r;
    logic                grant_s;
    memRequester_        grant_req_s;
    logic                done_s;
    logic                timeout_s;
    logic                fetch_ok_s;
    logic                force_fetch_s;

    // A flush in IDLE blocks the fetch grant; a starved fetch overrides data priority.
    assign fetch_ok_s    = fetchRequest && !fetchFlush;
    assign force_fetch_s = fetchRequest && (starve_r == STARVE_MAX);

    // Arbitration in IDLE and completion detection in the wait states
    always_comb begin
        state_s     = state_r;
        grant_s     = 1'b0;
        grant_req_s = REQ_FETCH;
        done_s      = 1'b0;
        case (state_r)
            ARB_IDLE: begin
                if (force_fetch_s && fetch_ok_s) begin
                    grant_s     = 1'b1;
                    grant_req_s = REQ_FETCH;
                end else if (storeValid) begin
                    grant_s     = 1'b1;
                    grant_req_s = REQ_STORE;
                end else if (loadRequest) begin
                    grant_s     = 1'b1;
                    grant_req_s = REQ_LOAD;
                end else if (fetch_ok_s) begin
                    grant_s     = 1'b1;
                    grant_req_s = REQ_FETCH;
                end else begin
                    grant_s     = 1'b0;
                end
                if (grant_s) begin
                    state_s = wait_state_for(grant_req_s);
                end else begin
                    state_s = ARB_IDLE;
                end
            end
            ARB_FETCH_WAIT, ARB_LOAD_WAIT, ARB_STORE_WAIT: begin
                if (memResponseValid || timeout_s) begin
                    done_s  = 1'b1;
                    state_s = ARB_IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            default: state_s = ARB_IDLE;
        endcase
    end

    // FSM state and the bus payload latched at grant, held until completion
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= ARB_IDLE;
            mem_req_r   <= 1'b0;
            mem_write_r <= 1'b0;
            mem_addr_r  <= 32'h0;
            mem_wdata_r <= 32'h0;
            mem_be_r    <= 4'b0000;
        end else begin
            state_r <= state_s;
            if (grant_s) begin
                mem_req_r   <= 1'b1;
                mem_write_r <= (grant_req_s == REQ_STORE);
                mem_addr_r  <= (grant_req_s == REQ_FETCH) ? fetchAddress : addressRegister;
                mem_wdata_r <= (grant_req_s == REQ_STORE) ? storeData : 32'h0;
                mem_be_r    <= (grant_req_s == REQ_STORE) ? storeByteEnable : 4'b1111;
            end else if (done_s) begin
                mem_req_r   <= 1'b0;
                mem_write_r <= 1'b0;
                mem_be_r    <= 4'b0000;
            end
        end
    end

    // Fetch starvation count and the flushed-fetch drain flag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starve_r <= {STARVE_W{1'b0}};
            drain_r  <= 1'b0;
        end else begin
            if (!fetchRequest || (grant_s && (grant_req_s == REQ_FETCH))) begin
                starve_r <= {STARVE_W{1'b0}};
            end else if (grant_s && (starve_r != STARVE_MAX)) begin
                starve_r <= starve_r + STARVE_ONE;
            end
            drain_r <= (state_r == ARB_FETCH_WAIT) && !done_s && (drain_r || fetchFlush);
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

    logic [WAIT_W-1:0] wait_cnt_r;

    // Wait-state cycle counter; zero on the first wait cycle of every transaction
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else if ((state_r == ARB_IDLE) || done_s) begin
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else begin
            wait_cnt_r <= wait_cnt_r + WAIT_ONE;
        end
    end

    assign timeout_s = (state_r != ARB_IDLE) && !memResponseValid && (wait_cnt_r == WAIT_LAST);
`else
    assign timeout_s = 1'b0;
`endif

    assign memRequest    = mem_req_r;
    assign memWrite      = mem_write_r;
    assign memAddress    = mem_addr_r;
    assign memWriteData  = mem_wdata_r;
    assign memByteEnable = mem_be_r;

    // Completions are returned in the response cycle; an aborted read returns zero.
    assign fetchValid    = (state_r == ARB_FETCH_WAIT) && done_s && !drain_r && !fetchFlush;
    assign loadDataValid = (state_r == ARB_LOAD_WAIT) && done_s;
    assign storeComplete = (state_r == ARB_STORE_WAIT) && done_s;
    assign fetchData     = timeout_s ? 32'h0 : memReadData;
    assign loadData      = timeout_s ? 32'h0 : memReadData;
    assign busError      = timeout_s;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed and randomized bench for memory_port_arbiter with a behavioural bus memory
// and transaction-level expectations derived from the arbitration rules.
module tb_memory_port_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        fetchRequest;
    logic [31:0] fetchAddress;
    logic        fetchFlush;
    logic [31:0] fetchData;
    logic        fetchValid;
    logic        loadRequest;
    logic        storeValid;
    logic [31:0] addressRegister;
    logic [31:0] storeData;
    logic [3:0]  storeByteEnable;
    logic [31:0] loadData;
    logic        loadDataValid;
    logic        storeComplete;
    logic        memRequest;
    logic        memWrite;
    logic [31:0] memAddress;
    logic [31:0] memWriteData;
    logic [3:0]  memByteEnable;
    logic [31:0] memReadData;
    logic        memResponseValid;
    logic        busError;

    memory_port_arbiter #(
        .FETCH_STARVE_LIMIT(4)
`ifdef MEM_ARB_TIMEOUT_EN
        , .TIMEOUT_CYCLES(8)
`endif
    ) dut (
        .clock(clock), .reset(reset),
        .fetchRequest(fetchRequest), .fetchAddress(fetchAddress), .fetchFlush(fetchFlush),
        .fetchData(fetchData), .fetchValid(fetchValid),
        .loadRequest(loadRequest), .storeValid(storeValid), .addressRegister(addressRegister),
        .storeData(storeData), .storeByteEnable(storeByteEnable),
        .loadData(loadData), .loadDataValid(loadDataValid), .storeComplete(storeComplete),
        .memRequest(memRequest), .memWrite(memWrite), .memAddress(memAddress),
        .memWriteData(memWriteData), .memByteEnable(memByteEnable),
        .memReadData(memReadData), .memResponseValid(memResponseValid), .busError(busError)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int fv_cnt = 0, ld_cnt = 0, sc_cnt = 0, be_cnt = 0;
    logic [31:0] fv_data_q[$];
    logic [31:0] ld_data_q[$];
    logic        g_write_q[$];
    logic [31:0] g_addr_q[$];
    logic [31:0] g_wdata_q[$];
    logic [3:0]  g_be_q[$];
    logic        prev_req = 1'b0;
    bit          mute = 1'b0;
    bit          force_pulse = 1'b0;
    bit          hold_load = 1'b0;
    int          lat = 1;
    int          wcnt = 0;
    logic [31:0] mem [int unsigned];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        int unsigned key = a >> 2;
        if (mem.exists(key)) return mem[key];
        return {a[15:0] ^ 16'h5A3C, a[15:0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, {31'h0, obs}, {31'h0, exp});
    endtask

    // One clock: bus responder acts after the edge, outputs are recorded on the falling edge.
    task automatic step();
        @(posedge clock);
        #1;
        if (mute) begin
            memResponseValid = 1'b0;
            wcnt = 0;
        end else if (memResponseValid) begin
            memResponseValid = 1'b0;
            wcnt = 0;
        end else if (force_pulse) begin
            memResponseValid = 1'b1;
            memReadData = 32'hBAD0BAD0;
            force_pulse = 1'b0;
        end else if (memRequest) begin
            if (wcnt >= lat - 1) begin
                memResponseValid = 1'b1;
                if (memWrite) mem[memAddress >> 2] = merge(mem_rd(memAddress), memWriteData, memByteEnable);
                else memReadData = mem_rd(memAddress);
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
        @(negedge clock);
        if (memRequest && !prev_req) begin
            g_write_q.push_back(memWrite);
            g_addr_q.push_back(memAddress);
            g_wdata_q.push_back(memWriteData);
            g_be_q.push_back(memByteEnable);
        end
        prev_req = memRequest;
        if (fetchValid) begin fv_cnt++; fv_data_q.push_back(fetchData); fetchRequest = 1'b0; end
        if (loadDataValid) begin
            ld_cnt++; ld_data_q.push_back(loadData);
            if (!hold_load) loadRequest = 1'b0;
        end
        if (storeComplete) begin sc_cnt++; storeValid = 1'b0; end
        if (busError) be_cnt++;
    endtask

    task automatic wait_fetch(input int target, input int budget, input string tag);
        int n = 0;
        while (fv_cnt < target && n < budget) begin step(); n++; end
        chk({tag, "_fetch_done"}, fv_cnt, target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks passed %0d", n_pass);
        $fatal(1, "watchdog");
    end

    int          b_fv, b_ld, b_sc, b_g, b_be, n, m;
    logic [31:0] exp_f, exp_ld, da, fa, sd, old;
    logic [3:0]  sbe;

    initial begin
        reset = 1'b0; fetchRequest = 1'b0; fetchAddress = 32'h0; fetchFlush = 1'b0;
        loadRequest = 1'b0; storeValid = 1'b0; addressRegister = 32'h0; storeData = 32'h0;
        storeByteEnable = 4'b0000; memReadData = 32'h0; memResponseValid = 1'b0;
        step(); step();
        chk1("rst_memRequest", memRequest, 1'b0);
        chk1("rst_memWrite", memWrite, 1'b0);
        chk("rst_memByteEnable", {28'h0, memByteEnable}, 32'h0);
        chk1("rst_fetchValid", fetchValid, 1'b0);
        chk1("rst_loadDataValid", loadDataValid, 1'b0);
        chk1("rst_storeComplete", storeComplete, 1'b0);
        chk1("rst_busError", busError, 1'b0);
        reset = 1'b1;
        step(); step();

        // Single fetch, 3-cycle bus latency
        mem[32'h100 >> 2] = 32'h00500093;
        lat = 3; b_fv = fv_cnt; b_g = g_addr_q.size();
        fetchAddress = 32'h100; fetchRequest = 1'b1;
        step();
        chk1("f1_req_next_cycle", memRequest, 1'b1);
        chk("f1_addr", memAddress, 32'h100);
        chk("f1_be", {28'h0, memByteEnable}, 32'hF);
        chk1("f1_write", memWrite, 1'b0);
        n = 1;
        while (fv_cnt == b_fv && n < 20) begin step(); n++; end
        chk("f1_latency", n, 3);
        chk("f1_data", fv_data_q[b_fv], 32'h00500093);
        repeat (3) step();
        chk("f1_pulse_count", fv_cnt - b_fv, 1);
        chk("f1_grant_count", g_addr_q.size() - b_g, 1);

        // Store, load and fetch raised together
        mem[32'h200 >> 2] = 32'h11223344;
        exp_f = mem_rd(32'h300);
        lat = 2; b_fv = fv_cnt; b_ld = ld_cnt; b_sc = sc_cnt; b_g = g_addr_q.size();
        storeValid = 1'b1; addressRegister = 32'h202; storeData = 32'hDEADBEEF;
        storeByteEnable = 4'b1100; loadRequest = 1'b1;
        fetchRequest = 1'b1; fetchAddress = 32'h300;
        wait_fetch(b_fv + 1, 60, "ord");
        repeat (3) step();
        chk("ord_grant_count", g_addr_q.size() - b_g, 3);
        chk1("ord_g0_write", g_write_q[b_g], 1'b1);
        chk("ord_g0_addr", g_addr_q[b_g], 32'h202);
        chk("ord_g0_be", {28'h0, g_be_q[b_g]}, 32'hC);
        chk("ord_g0_wdata", g_wdata_q[b_g], 32'hDEADBEEF);
        chk1("ord_g1_write", g_write_q[b_g+1], 1'b0);
        chk("ord_g1_addr", g_addr_q[b_g+1], 32'h202);
        chk("ord_g1_be", {28'h0, g_be_q[b_g+1]}, 32'hF);
        chk("ord_g2_addr", g_addr_q[b_g+2], 32'h300);
        chk("ord_store_pulses", sc_cnt - b_sc, 1);
        chk("ord_load_pulses", ld_cnt - b_ld, 1);
        chk("ord_load_data", ld_data_q[b_ld], 32'hDEAD3344);
        chk("ord_fetch_data", fv_data_q[b_fv], exp_f);

        // Loads held back-to-back starve a waiting fetch
        lat = 1; b_fv = fv_cnt; b_ld = ld_cnt; b_g = g_addr_q.size();
        hold_load = 1'b1; loadRequest = 1'b1; addressRegister = 32'h10;
        fetchRequest = 1'b1; fetchAddress = 32'h80;
        wait_fetch(b_fv + 1, 80, "starve");
        loadRequest = 1'b0; hold_load = 1'b0;
        repeat (3) step();
        chk("starve_load_grants", ld_cnt - b_ld, 4);
        chk("starve_grant_count", g_addr_q.size() - b_g, 5);
        chk("starve_g0_addr", g_addr_q[b_g], 32'h10);
        chk("starve_g3_addr", g_addr_q[b_g+3], 32'h10);
        chk("starve_g4_addr", g_addr_q[b_g+4], 32'h80);

        // Flush during FETCH_WAIT, then flush in IDLE, then a normal fetch
        lat = 3; b_fv = fv_cnt;
        fetchRequest = 1'b1; fetchAddress = 32'h500;
        step();
        fetchFlush = 1'b1; fetchRequest = 1'b0;
        step();
        fetchFlush = 1'b0;
        repeat (6) step();
        chk("flush_no_fetchValid", fv_cnt - b_fv, 0);
        chk1("flush_back_idle", memRequest, 1'b0);
        mem[32'h40 >> 2] = 32'h12345678;
        fetchRequest = 1'b1; fetchAddress = 32'h40; fetchFlush = 1'b1;
        step();
        chk1("flush_idle_no_grant", memRequest, 1'b0);
        fetchFlush = 1'b0;
        wait_fetch(b_fv + 1, 20, "after_flush");
        chk("after_flush_data", fv_data_q[b_fv], 32'h12345678);

        // Reset asserted mid-LOAD_WAIT; a later stray response is ignored
        lat = 2; mute = 1'b1;
        loadRequest = 1'b1; addressRegister = 32'h30;
        step(); step();
        chk1("rl_inflight", memRequest, 1'b1);
        reset = 1'b0;
        #1;
        chk1("rl_memRequest", memRequest, 1'b0);
        chk1("rl_loadDataValid", loadDataValid, 1'b0);
        chk1("rl_memWrite", memWrite, 1'b0);
        chk("rl_memByteEnable", {28'h0, memByteEnable}, 32'h0);
        loadRequest = 1'b0;
        step(); step();
        reset = 1'b1;
        mute = 1'b0; force_pulse = 1'b1;
        b_ld = ld_cnt; b_fv = fv_cnt; b_sc = sc_cnt;
        step(); step();
        chk("rl_stray_load", ld_cnt - b_ld, 0);
        chk("rl_stray_other", (fv_cnt - b_fv) + (sc_cnt - b_sc), 0);
        chk1("rl_idle", memRequest, 1'b0);

        // Random mixes of simultaneous requests with random bus latency
        for (int r = 0; r < 24; r++) begin
            m   = int'($urandom_range(1, 7));
            lat = int'($urandom_range(1, 4));
            da  = 32'($urandom_range(0, 255));
            fa  = 32'h1000 + 32'($urandom_range(0, 63)) * 32'd4;
            sd  = $urandom;
            sbe = 4'($urandom_range(1, 15));
            old = mem_rd(da);
            exp_ld = m[2] ? merge(old, sd, sbe) : old;
            exp_f  = mem_rd(fa);
            b_fv = fv_cnt; b_ld = ld_cnt; b_sc = sc_cnt; b_g = g_addr_q.size();
            storeValid = m[2]; loadRequest = m[1]; fetchRequest = m[0];
            addressRegister = da; storeData = sd; storeByteEnable = sbe; fetchAddress = fa;
            n = 0;
            while ((storeValid || loadRequest || fetchRequest) && n < 100) begin step(); n++; end
            chk1("rnd_all_completed", storeValid || loadRequest || fetchRequest, 1'b0);
            step(); step();
            n = b_g;
            if (m[2]) begin
                chk1("rnd_store_write", g_write_q[n], 1'b1);
                chk("rnd_store_addr", g_addr_q[n], da);
                chk("rnd_store_wdata", g_wdata_q[n], sd);
                chk("rnd_store_be", {28'h0, g_be_q[n]}, {28'h0, sbe});
                n++;
            end
            if (m[1]) begin
                chk1("rnd_load_write", g_write_q[n], 1'b0);
                chk("rnd_load_addr", g_addr_q[n], da);
                chk("rnd_load_data", ld_data_q[b_ld], exp_ld);
                n++;
            end
            if (m[0]) begin
                chk("rnd_fetch_addr", g_addr_q[n], fa);
                chk("rnd_fetch_data", fv_data_q[b_fv], exp_f);
                n++;
            end
            chk("rnd_grant_count", g_addr_q.size() - b_g, n - b_g);
            chk("rnd_pulses", (fv_cnt - b_fv) + (ld_cnt - b_ld) + (sc_cnt - b_sc),
                32'(m[0]) + 32'(m[1]) + 32'(m[2]));
        end

`ifdef MEM_ARB_TIMEOUT_EN
        // Unanswered load aborts on wait cycle 8
        mute = 1'b1; b_be = be_cnt; b_ld = ld_cnt;
        addressRegister = 32'h44; loadRequest = 1'b1;
        step();
        n = 1;
        while (be_cnt == b_be && n < 20) begin step(); n++; end
        chk("to_wait_cycle", n, 8);
        chk("to_load_pulse", ld_cnt - b_ld, 1);
        chk("to_load_data", ld_data_q[b_ld], 32'h0);
        step();
        chk1("to_idle", memRequest, 1'b0);
        mute = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
